// File: rtl/system_0_nios2_qsys_0_cpu_debug_host_if.sv
// Command/response port of the virtual-JTAG debug host.
//
// Handshake rule for the whole interface: a command transfers on any rising
// clk edge where cmd_valid and cmd_ready are both high. cmd_ready is high only
// while the host is idle; cmd_valid seen while busy is dropped, not queued.
// rsp_valid is a one-cycle pulse with no back-pressure; rsp_data/rsp_ir stay
// valid until the next pulse.
//
// Signals:
//   cmd_valid/cmd_ready  command handshake
//   cmd_ir [1:0]         IR value for the scan
//   cmd_data [DR_W-1:0]  data shifted out on tdi, LSB first
//   rsp_valid            scan complete pulse
//   rsp_data [DR_W-1:0]  captured tdo bits, LSB = first bit shifted
//   rsp_ir [1:0]         ir_out captured during UIR
//   busy                 scan in progress (inverse of cmd_ready)
interface system_0_nios2_qsys_0_cpu_debug_host_if #(
  parameter int DR_W = 38
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_ir;
  logic [DR_W-1:0] cmd_data;
  logic            rsp_valid;
  logic [DR_W-1:0] rsp_data;
  logic [1:0]      rsp_ir;
  logic            busy;

  modport master (
    output cmd_valid, cmd_ir, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir, busy
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir, busy
  );
endinterface

// File: rtl/system_0_nios2_qsys_0_cpu_debug_host.sv
// Host-side virtual-JTAG scan driver for the Nios II debug slave.
// One accepted command produces a complete scan UIR, CDR, DR_W x SDR, UDR,
// RTI, each step lasting whole tck periods of 2*TCK_DIV clk cycles (low half
// first). State, strobes, tdi and the SDR bit index change together when the
// phase counter wraps, i.e. as tck falls, so tdi is stable across the whole
// high half of tck.
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   host                 command/response interface (slave modport)
//   tck, tdi, tdo        generated test clock, serial data out/in
//   ir_in, ir_out        IR presented to / read back from the slave
//   vs_uir .. jtag_state_rti  one-hot virtual state strobes (all 0 when idle)
//   dbg_state            current scan state encoding, for observation
module system_0_nios2_qsys_0_cpu_debug_host #(
  parameter int TCK_DIV = 2,
  parameter int DR_W    = 38
) (
  input  logic       clk,
  input  logic       reset_n,
  system_0_nios2_qsys_0_cpu_debug_host_if.slave host,
  output logic       tck,
  output logic       tdi,
  input  logic       tdo,
  output logic [1:0] ir_in,
  input  logic [1:0] ir_out,
  output logic       vs_uir,
  output logic       vs_cdr,
  output logic       vs_sdr,
  output logic       vs_udr,
  output logic       jtag_state_rti,
  output logic [2:0] dbg_state
);

  localparam int PERIOD = 2 * TCK_DIV;
  localparam int PC_W   = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int BI_W   = (DR_W > 2) ? $clog2(DR_W) : 1;
  localparam logic [PC_W-1:0] PC_HALF = PC_W'(TCK_DIV);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PERIOD - 1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(DR_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RTI  = 3'd5
  } state_t;

  state_t          state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic [BI_W-1:0] bit_idx;
  logic [DR_W-1:0] data_sh;
  logic [DR_W-1:0] cap_sh;
  logic [1:0]      ir_cap;
  logic            accept, wrap, rise;

  assign accept = host.cmd_valid && (state == ST_IDLE);
  // Last clk cycle of a tck period: the next edge is a period boundary.
  assign wrap   = (state != ST_IDLE) && (pc == PC_LAST);

  always_comb begin
    state_next = state;
    pc_next    = '0;
    if ((state != ST_IDLE) && !wrap) pc_next = pc + 1'b1;
    case (state)
      ST_IDLE: if (accept) state_next = ST_UIR;
      ST_UIR:  if (wrap) state_next = ST_CDR;
      ST_CDR:  if (wrap) state_next = ST_SDR;
      ST_SDR:  if (wrap && (bit_idx == BI_LAST)) state_next = ST_UDR;
      ST_UDR:  if (wrap) state_next = ST_RTI;
      ST_RTI:  if (wrap) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The edge that is about to drive tck high; tdo and ir_out are sampled here.
  assign rise = (state != ST_IDLE) && (pc_next == PC_HALF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      pc    <= '0;
      tck   <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      tck   <= (state_next != ST_IDLE) && (pc_next >= PC_HALF);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_in          <= 2'b00;
      data_sh        <= '0;
      bit_idx        <= '0;
      cap_sh         <= '0;
      ir_cap         <= 2'b00;
      tdi            <= 1'b0;
      host.rsp_valid <= 1'b0;
      host.rsp_data  <= '0;
      host.rsp_ir    <= 2'b00;
    end else begin
      if (accept) begin
        ir_in   <= host.cmd_ir;
        data_sh <= host.cmd_data;
        bit_idx <= '0;
      end
      if (rise && (state == ST_UIR)) ir_cap <= ir_out;
      // MSB-first shift so the first captured bit ends up in bit 0.
      if (rise && (state == ST_SDR)) cap_sh <= {tdo, cap_sh[DR_W-1:1]};
      if (wrap) begin
        if (state_next == ST_SDR) begin
          tdi     <= data_sh[0];
          data_sh <= data_sh >> 1;
        end else begin
          tdi <= 1'b0;
        end
        if ((state == ST_SDR) && (bit_idx != BI_LAST)) bit_idx <= bit_idx + 1'b1;
      end
      host.rsp_valid <= (state == ST_RTI) && wrap;
      if ((state == ST_RTI) && wrap) begin
        host.rsp_data <= cap_sh;
        host.rsp_ir   <= ir_cap;
      end
    end
  end

  assign host.cmd_ready = (state == ST_IDLE);
  assign host.busy      = (state != ST_IDLE);
  assign vs_uir         = (state == ST_UIR);
  assign vs_cdr         = (state == ST_CDR);
  assign vs_sdr         = (state == ST_SDR);
  assign vs_udr         = (state == ST_UDR);
  assign jtag_state_rti = (state == ST_RTI);
  assign dbg_state      = state;

endmodule

// File: tb/tb_system_0_nios2_qsys_0_cpu_debug_host.sv
module tb_system_0_nios2_qsys_0_cpu_debug_host;
  localparam int DR_W = 38;
  localparam int T0   = 2;
  localparam int T1   = 1;
  localparam int P0   = (DR_W + 4) * 2 * T0;
  localparam int P1   = (DR_W + 4) * 2 * T1;

  logic clk, reset_n;

  system_0_nios2_qsys_0_cpu_debug_host_if #(.DR_W(DR_W)) if0 ();
  system_0_nios2_qsys_0_cpu_debug_host_if #(.DR_W(DR_W)) if1 ();

  logic       tck0, tdi0, tdo0, vs_uir0, vs_cdr0, vs_sdr0, vs_udr0, rti0;
  logic [1:0] ir_in0, ir_out0;
  logic [2:0] dbg0;
  logic       tck1, tdi1, tdo1, vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1;
  logic [1:0] ir_in1, ir_out1;
  logic [2:0] dbg1;

  system_0_nios2_qsys_0_cpu_debug_host #(.TCK_DIV(T0), .DR_W(DR_W)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .host(if0),
    .tck(tck0), .tdi(tdi0), .tdo(tdo0), .ir_in(ir_in0), .ir_out(ir_out0),
    .vs_uir(vs_uir0), .vs_cdr(vs_cdr0), .vs_sdr(vs_sdr0), .vs_udr(vs_udr0),
    .jtag_state_rti(rti0), .dbg_state(dbg0)
  );

  system_0_nios2_qsys_0_cpu_debug_host #(.TCK_DIV(T1), .DR_W(DR_W)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .host(if1),
    .tck(tck1), .tdi(tdi1), .tdo(tdo1), .ir_in(ir_in1), .ir_out(ir_out1),
    .vs_uir(vs_uir1), .vs_cdr(vs_cdr1), .vs_sdr(vs_sdr1), .vs_udr(vs_udr1),
    .jtag_state_rti(rti1), .dbg_state(dbg1)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bench state ----------------
  int vec_count = 0;
  int err_count = 0;
  logic [DR_W-1:0] exp_q[$];
  logic [1:0]      exp_ir_q[$];
  logic [DR_W-1:0] slave_sr0, slave_sr1;   // loopback slave environment
  logic [DR_W-1:0] ref_sr0;                // reference: slave content before next scan
  logic [DR_W-1:0] cur_data0;
  logic [1:0]      cur_ir0;
  logic            tck0_prev, tck1_prev;

  // Spec-level strobe pattern {uir,cdr,sdr,udr,rti} for tck period number per.
  function automatic logic [4:0] exp_strobes(input int per);
    if (per == 0)             return 5'b10000;
    else if (per == 1)        return 5'b01000;
    else if (per <= DR_W + 1) return 5'b00100;
    else if (per == DR_W + 2) return 5'b00010;
    else if (per == DR_W + 3) return 5'b00001;
    else                      return 5'b00000;
  endfunction

  function automatic logic [13:0] ctl0();
    return {tck0, tdi0, ir_in0, vs_uir0, vs_cdr0, vs_sdr0, vs_udr0, rti0,
            if0.cmd_ready, if0.busy, if0.rsp_valid, if0.rsp_ir};
  endfunction

  function automatic logic [13:0] ctl1();
    return {tck1, tdi1, ir_in1, vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1,
            if1.cmd_ready, if1.busy, if1.rsp_valid, if1.rsp_ir};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clk cycle and sample #1 after the edge. The loopback slaves
  // shift on every rising tck seen in SDR: tdi in at the MSB, tdo = bit 0.
  task automatic step();
    @(posedge clk);
    #1;
    if (tck0 && !tck0_prev && vs_sdr0) slave_sr0 = {tdi0, slave_sr0[DR_W-1:1]};
    if (tck1 && !tck1_prev && vs_sdr1) slave_sr1 = {tdi1, slave_sr1[DR_W-1:1]};
    tck0_prev = tck0;
    tck1_prev = tck1;
    tdo0 = slave_sr0[0];
    tdo1 = slave_sr1[0];
  endtask

  task automatic rand_data(output logic [DR_W-1:0] d);
    logic [63:0] r;
    r = {$urandom, $urandom};
    d = r[DR_W-1:0];
  endtask

  task automatic preload0(input logic [DR_W-1:0] v);
    slave_sr0 = v;
    ref_sr0   = v;
    tdo0      = v[0];
  endtask

  // Present a command to dut0 at the current sample point; returns one
  // cycle after acceptance with the inputs scrambled.
  task automatic start_cmd0(input logic [1:0] ir, input logic [DR_W-1:0] data);
    logic [DR_W-1:0] junk;
    vec_count++;
    if (if0.cmd_ready !== 1'b1) begin
      err_count++;
      $display("FAIL ready_before_accept: got %b, want 1", if0.cmd_ready);
    end
    ir_out0 = 2'($urandom_range(0, 3));
    if0.cmd_valid = 1'b1;
    if0.cmd_ir    = ir;
    if0.cmd_data  = data;
    exp_q.push_back(ref_sr0);
    exp_ir_q.push_back(ir_out0);
    ref_sr0   = data;
    cur_data0 = data;
    cur_ir0   = ir;
    step();
    rand_data(junk);
    if0.cmd_valid = 1'b0;
    if0.cmd_ir    = ~ir;
    if0.cmd_data  = junk;
  endtask

  // Follow a dut0 scan from the cycle after acceptance until rsp_valid.
  // busy_at >= 0 pulses cmd_valid with unrelated data at that cycle.
  task automatic wait_scan0(input int busy_at);
    int n, per, ph, bad, first_bad, rises;
    logic [4:0] obs, exp_s;
    logic exp_tck, ok, prev;
    logic [DR_W-1:0] tdi_seen, junk, e_data;
    logic [1:0] e_ir;
    n = 0; bad = 0; first_bad = -1; rises = 0; prev = 1'b0; tdi_seen = '0;
    while (!if0.rsp_valid && n < P0 + 20) begin
      per     = n / (2 * T0);
      ph      = n % (2 * T0);
      exp_s   = exp_strobes(per);
      exp_tck = (ph >= T0);
      obs     = {vs_uir0, vs_cdr0, vs_sdr0, vs_udr0, rti0};
      ok = (obs === exp_s) && (tck0 === exp_tck) && (if0.busy === 1'b1) &&
           (if0.cmd_ready === 1'b0) && (ir_in0 === cur_ir0);
      if (per >= 2 && per <= DR_W + 1 && exp_tck) ok = ok && (tdi0 === cur_data0[per-2]);
      if (!ok) begin
        bad++;
        if (first_bad < 0) first_bad = n;
      end
      if (tck0 && !prev && vs_sdr0) begin
        if (rises < DR_W) tdi_seen[rises] = tdi0;
        rises++;
      end
      prev = tck0;
      if (n == busy_at) begin
        rand_data(junk);
        if0.cmd_valid = 1'b1;
        if0.cmd_data  = junk;
        if0.cmd_ir    = ~cur_ir0;
      end else if (n == busy_at + 1) begin
        if0.cmd_valid = 1'b0;
      end
      step();
      n++;
    end
    if0.cmd_valid = 1'b0;
    e_data = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    e_ir   = (exp_ir_q.size() > 0) ? exp_ir_q.pop_front() : 2'b00;

    vec_count++;
    if (bad != 0) begin
      err_count++;
      $display("FAIL scan_waveform: %0d bad cycles, first at cycle %0d, want 0", bad, first_bad);
    end
    vec_count++;
    if (if0.rsp_valid !== 1'b1 || n != P0) begin
      err_count++;
      $display("FAIL rsp_latency: rsp_valid=%b at cycle %0d, want 1 at cycle %0d", if0.rsp_valid, n, P0);
    end
    vec_count++;
    if (if0.rsp_data !== e_data) begin
      err_count++;
      $display("FAIL rsp_data: got %h, want %h", if0.rsp_data, e_data);
    end
    vec_count++;
    if (if0.rsp_ir !== e_ir) begin
      err_count++;
      $display("FAIL rsp_ir: got %b, want %b", if0.rsp_ir, e_ir);
    end
    vec_count++;
    if (rises != DR_W || tdi_seen !== cur_data0) begin
      err_count++;
      $display("FAIL tdi_stream: %0d sdr rises, bits %h, want %0d rises, bits %h", rises, tdi_seen, DR_W, cur_data0);
    end
    vec_count++;
    if (if0.cmd_ready !== 1'b1 || if0.busy !== 1'b0 || rti0 !== 1'b0) begin
      err_count++;
      $display("FAIL end_of_scan: ready=%b busy=%b rti=%b, want 1 0 0", if0.cmd_ready, if0.busy, rti0);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    if0.cmd_valid = 1'b0; if0.cmd_ir = 2'b00; if0.cmd_data = '0;
    if1.cmd_valid = 1'b0; if1.cmd_ir = 2'b00; if1.cmd_data = '0;
    ir_out0 = 2'b00; ir_out1 = 2'b00;
    tck0_prev = 1'b0; tck1_prev = 1'b0;
    slave_sr1 = '0; preload0('0); tdo1 = 1'b0;
    repeat (3) step();
    vec_count++;
    if (ctl0() !== 14'h0010 || if0.rsp_data !== '0) begin
      err_count++;
      $display("FAIL reset_dut0: ctl %h data %h, want 0010 0", ctl0(), if0.rsp_data);
    end
    vec_count++;
    if (ctl1() !== 14'h0010 || if1.rsp_data !== '0) begin
      err_count++;
      $display("FAIL reset_dut1: ctl %h data %h, want 0010 0", ctl1(), if1.rsp_data);
    end
    reset_n = 1'b1;
    step();
    vec_count++;
    if (if0.cmd_ready !== 1'b1 || if1.cmd_ready !== 1'b1 || if0.busy !== 1'b0) begin
      err_count++;
      $display("FAIL ready_after_reset: %b %b busy %b, want 1 1 0", if0.cmd_ready, if1.cmd_ready, if0.busy);
    end
  endtask

  task automatic test_single_scan();
    preload0(38'h15_5555_5555);
    start_cmd0(2'b01, 38'h0_1234_5678);
    wait_scan0(-1);
    vec_count++;
    if (slave_sr0 !== 38'h0_1234_5678) begin
      err_count++;
      $display("FAIL slave_loaded: got %h, want %h", slave_sr0, 38'h0_1234_5678);
    end
  endtask

  task automatic test_back_to_back();
    logic [DR_W-1:0] d;
    // Presented during the rsp_valid cycle left by the previous scan.
    start_cmd0(2'b10, 38'h3F_FFFF_FFFF);
    wait_scan0(-1);
    for (int i = 0; i < 3; i++) begin
      rand_data(d);
      start_cmd0(2'($urandom_range(0, 3)), d);
      wait_scan0(-1);
    end
  endtask

  task automatic test_busy_ignore();
    logic [DR_W-1:0] d;
    int bad;
    step();
    rand_data(d);
    start_cmd0(2'($urandom_range(0, 3)), d);
    wait_scan0(49);   // cycle 50 counted from acceptance
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (if0.rsp_valid !== 1'b0 || if0.busy !== 1'b0) bad++;
    end
    vec_count++;
    if (bad != 0) begin
      err_count++;
      $display("FAIL busy_not_queued: %0d cycles with rsp_valid/busy, want 0", bad);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [DR_W-1:0] d;
    int bad;
    rand_data(d);
    preload0(d);
    rand_data(d);
    start_cmd0(2'b11, d);
    repeat (59) step();
    reset_n = 1'b0;
    #1;
    vec_count++;
    if (ctl0() !== 14'h0010 || if0.rsp_data !== '0) begin
      err_count++;
      $display("FAIL reset_mid_scan: ctl %h data %h, want 0010 0", ctl0(), if0.rsp_data);
    end
    bad = 0;
    repeat (3) begin
      step();
      if (if0.rsp_valid !== 1'b0 || if0.busy !== 1'b0) bad++;
    end
    reset_n = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_ir_q.pop_back());
    rand_data(d);
    preload0(d);
    for (int i = 0; i < 200; i++) begin
      step();
      if (if0.rsp_valid !== 1'b0 || if0.busy !== 1'b0) bad++;
    end
    vec_count++;
    if (bad != 0) begin
      err_count++;
      $display("FAIL aborted_no_rsp: %0d bad cycles, want 0", bad);
    end
    rand_data(d);
    start_cmd0(2'b01, d);
    wait_scan0(-1);
  endtask

  task automatic test_tck_div1();
    int n, bad;
    logic [1:0] e_ir;
    slave_sr1 = 38'h15_5555_5555;
    tdo1 = slave_sr1[0];
    ir_out1 = 2'($urandom_range(0, 3));
    e_ir = ir_out1;
    vec_count++;
    if (if1.cmd_ready !== 1'b1) begin
      err_count++;
      $display("FAIL div1_ready: got %b, want 1", if1.cmd_ready);
    end
    if1.cmd_valid = 1'b1;
    if1.cmd_ir    = 2'b01;
    if1.cmd_data  = 38'h0_1234_5678;
    step();
    if1.cmd_valid = 1'b0;
    if1.cmd_data  = '0;
    n = 0; bad = 0;
    while (!if1.rsp_valid && n < P1 + 20) begin
      if (tck1 !== ((n % 2) == 1) || if1.busy !== 1'b1) bad++;
      step();
      n++;
    end
    vec_count++;
    if (bad != 0) begin
      err_count++;
      $display("FAIL div1_tck_toggle: %0d bad cycles, want 0", bad);
    end
    vec_count++;
    if (if1.rsp_valid !== 1'b1 || n != P1) begin
      err_count++;
      $display("FAIL div1_latency: rsp_valid=%b at cycle %0d, want 1 at cycle %0d", if1.rsp_valid, n, P1);
    end
    vec_count++;
    if (if1.rsp_data !== 38'h15_5555_5555 || if1.rsp_ir !== e_ir) begin
      err_count++;
      $display("FAIL div1_rsp: data %h ir %b, want %h %b", if1.rsp_data, if1.rsp_ir, 38'h15_5555_5555, e_ir);
    end
    vec_count++;
    if (slave_sr1 !== 38'h0_1234_5678 || ir_in1 !== 2'b01) begin
      err_count++;
      $display("FAIL div1_slave: sr %h ir_in %b, want %h 01", slave_sr1, ir_in1, 38'h0_1234_5678);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single_scan();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_scan();
    test_tck_div1();
    vec_count++;
    if (exp_q.size() != 0) begin
      err_count++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/system_0_nios2_qsys_0_cpu_debug_host.md
# system_0_nios2_qsys_0_cpu_debug_host

Host-side driver for the Nios II debug slave's virtual-JTAG port. It turns one command (2-bit IR plus 38-bit data) into a complete virtual-JTAG scan: UIR, CDR, 38×SDR, UDR, RTI. It generates `tck`, `tdi` and the virtual state strobes, and captures `tdo` into a 38-bit response. It sits opposite the debug slave's TCK-domain logic in simulation benches and in the bring-up harness, replacing the hard JTAG hub.

## Interface
- `TCK_DIV`, default 2: `tck` half-period in `clk` cycles; must be ≥1.
- `DR_W`, default 38: scan data-register length in bits.

Ports:
- `clk`  in  1  system clock; all logic synchronous to the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  block idle; a command is accepted on `cmd_valid & cmd_ready`.
- `cmd_ir`  in  2  IR value for this scan.
- `cmd_data`  in  DR_W  data shifted out on `tdi`, LSB first.
- `rsp_valid`  out  1  one-cycle pulse: scan complete.
- `rsp_data`  out  DR_W  captured `tdo` bits, LSB = first bit shifted; held until the next `rsp_valid`.
- `rsp_ir`  out  2  `ir_out` sampled during UIR.
- `busy`  out  1  scan in progress (equals `~cmd_ready`).
- `tck`  out  1  generated test clock.
- `tdi`  out  1  serial data to the slave.
- `tdo`  in  1  serial data from the slave.
- `ir_in`  out  2  IR presented to the slave.
- `ir_out`  in  2  IR readback from the slave.
- `vs_uir`, `vs_cdr`, `vs_sdr`, `vs_udr`, `jtag_state_rti`  out  1 each  virtual state strobes.

## Operation
- States: IDLE → UIR → CDR → SDR → UDR → RTI → IDLE.
- Each non-IDLE state lasts an integer number of `tck` periods (2·TCK_DIV `clk` cycles):
  - UIR: 1 period.
  - CDR: 1 period.
  - SDR: DR_W periods.
  - UDR: 1 period.
  - RTI: 1 period.
- Phase counter `pc` runs 0..2·TCK_DIV−1 in every non-IDLE state. `tck` = (`pc` ≥ TCK_DIV), registered, so each period is low half then high half.
- At a period boundary (`pc` wraps to 0, `tck` falling), the following update together: state, strobes, `tdi`, SDR bit index.
- Exactly one strobe is high in each non-IDLE state, matching that state. All strobes are 0 in IDLE.
- `ir_in` is loaded from `cmd_ir` at acceptance and held until the next acceptance.
- SDR bit k (k = 0..DR_W−1) drives `tdi` = `cmd_data[k]`. `tdo` is sampled on the `clk` edge that drives `tck` high and shifted in MSB-first into the capture register, so `rsp_data[k]` = `tdo` at the k-th SDR rising edge.
- `ir_out` is sampled into `rsp_ir` on the rising `tck` edge of UIR.
- `cmd_data` is registered at acceptance; input changes after acceptance have no effect.
- `cmd_valid` while busy is ignored: not queued, no error.
- Reset mid-scan: all state and outputs return to reset values at once; no `rsp_valid` is issued for the aborted scan.

## Timing
- Reset values: `tck`=0, `tdi`=0, `ir_in`=0, all strobes 0, `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_ir`=0.
- Acceptance at edge E0:
  - From E0, `vs_uir`=1, `pc`=0, `cmd_ready`=0.
  - `tck` first rises at E0+TCK_DIV.
- Scan length: P = (DR_W+4)·2·TCK_DIV cycles; 168 cycles at the defaults.
- At edge E0+P:
  - `jtag_state_rti` drops, `rsp_valid`=1 for one cycle, `cmd_ready`=1.
  - `rsp_data` and `rsp_ir` update on the same edge.
- Back-to-back: a command presented during the `rsp_valid` cycle is accepted on that edge, with zero idle cycles between scans.
- `tdi` is stable for the whole high half of `tck`, matching the slave's rising-edge shift.

## Test plan
- Reset: hold `reset_n`=0 → all outputs equal the reset values above; `cmd_ready`=1 on release.
- Single scan, default parameters, loopback slave model (38-bit shift register preloaded 38'h15_5555_5555, `tdo`=sr[0]), `cmd_ir`=2'b01, `cmd_data`=38'h0_1234_5678:
  - `ir_in`=01 and `vs_uir` high for cycles 1–4.
  - 38 `tck` rising edges occur with `vs_sdr`=1, `tdi` LSB first.
  - `rsp_valid` at cycle 168, `rsp_data`=38'h15_5555_5555, model sr=38'h0_1234_5678.
- Back-to-back: second command (`cmd_data`=38'h3F_FFFF_FFFF) presented in the `rsp_valid` cycle → accepted the same edge; second `rsp_data`=38'h0_1234_5678.
- Busy: pulse `cmd_valid` with other data at cycle 50 → ignored; only one `rsp_valid`; `rsp_data` unaffected.
- Reset mid-SDR: assert `reset_n`=0 at cycle 60 for 3 cycles → outputs reset immediately, no `rsp_valid`; next command completes normally.
- `TCK_DIV`=1: the single-scan stimulus gives `rsp_valid` at cycle 84, with `tck` toggling every cycle.
